// File: rtl/tilt_letter_buffer_pkg.sv
// Shared constants and helpers for the tilt letter entry path.
// ASCII_A/LETTER_COUNT define the 26-letter alphabet mapping and
// BLANK_DEFAULT is the fill value of an empty slot. The code helpers are
// reused by the display block. buf_op_e names the single action chosen
// per clock edge.
package tilt_letter_buffer_pkg;

  localparam logic [7:0] ASCII_A       = 8'h41;
  localparam logic [7:0] BLANK_DEFAULT = 8'h20;
  localparam logic [7:0] LETTER_COUNT  = 8'd26;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_CLR,
    OP_DEL,
    OP_APPEND
  } buf_op_e;

  function automatic logic code_is_valid(input logic [7:0] code);
    return code < LETTER_COUNT;
  endfunction

  function automatic logic [7:0] code_to_ascii(input logic [7:0] code);
    return ASCII_A + code;
  endfunction

endpackage

// File: rtl/tilt_letter_buffer_edge.sv
// tilt_edge_detect: per-bit rising-edge detector.
// Ports: clk, reset (synchronous, active-low), d [W] level inputs,
//        rise [W] high in the cycle a bit goes 0->1 relative to last edge.
// The history register resets to 1 so a level held through reset release
// does not register as a rising edge.
module tilt_edge_detect #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);

  logic [W-1:0] d_q;

  always_ff @(posedge clk) begin
    if (!reset) d_q <= '1;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/tilt_letter_buffer.sv
// tilt_letter_buffer: converts a {tilt, switch} code into an uppercase ASCII
// letter and maintains a DEPTH-slot word buffer with append, delete-last and
// clear.
// Ports: clk; reset (sync, active-low); en/del edge-detected append/delete
//        requests; clr sync clear (level); tilt_input/switch_input code;
//        letters (slot i at [8*i+7:8*i], slot 0 oldest); count; full; empty;
//        err (one-cycle pulse after a rejected command).
module tilt_letter_buffer
  import tilt_letter_buffer_pkg::*;
#(
  parameter int unsigned DEPTH          = 3,
  parameter int unsigned TILT_W         = 2,
  parameter int unsigned SW_W           = 3,
  parameter int unsigned OVERFLOW_SHIFT = 0,
  parameter logic [7:0]  BLANK          = BLANK_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       del,
  input  logic                       clr,
  input  logic [TILT_W-1:0]          tilt_input,
  input  logic [SW_W-1:0]            switch_input,
  output logic [8*DEPTH-1:0]         letters,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [8*DEPTH-1:0] letters_q, letters_d;
  logic [CW-1:0]      count_q, count_d;
  logic               err_q, err_d;
  logic [1:0]         rise;
  logic [7:0]         code;
  logic [7:0]         letter;
  buf_op_e            op;

  // rise[0] = en edge, rise[1] = del edge
  tilt_edge_detect #(.W(2)) u_edge (
    .clk   (clk),
    .reset (reset),
    .d     ({del, en}),
    .rise  (rise)
  );

  assign code   = 8'({tilt_input, switch_input});
  assign letter = code_to_ascii(code);

  always_comb begin
    op = OP_NONE;
    if (clr)          op = OP_CLR;
    else if (rise[1]) op = OP_DEL;
    else if (rise[0]) op = OP_APPEND;
  end

  always_comb begin
    letters_d = letters_q;
    count_d   = count_q;
    err_d     = 1'b0;
    case (op)
      OP_CLR: begin
        letters_d = {DEPTH{BLANK}};
        count_d   = '0;
      end
      OP_DEL: begin
        if (count_q == '0) begin
          err_d = 1'b1;
        end else begin
          letters_d[8*(int'(count_q)-1) +: 8] = BLANK;
          count_d = count_q - CW'(1);
        end
      end
      OP_APPEND: begin
        if (!code_is_valid(code)) begin
          err_d = 1'b1;
        end else if (count_q < CW'(DEPTH)) begin
          letters_d[8*int'(count_q) +: 8] = letter;
          count_d = count_q + CW'(1);
        end else if (OVERFLOW_SHIFT != 0) begin
          // Oldest letter drops out of slot 0; the new one lands in the top slot.
          for (int unsigned i = 0; i + 1 < DEPTH; i++)
            letters_d[8*i +: 8] = letters_q[8*(i+1) +: 8];
          letters_d[8*(DEPTH-1) +: 8] = letter;
        end else begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      letters_q <= {DEPTH{BLANK}};
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      letters_q <= letters_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  assign letters = letters_q;
  assign count   = count_q;
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign err     = err_q;

endmodule

// File: tb/tb_tilt_letter_buffer.sv
module tb_tilt_letter_buffer;

  localparam logic [7:0] B = 8'h20;

  logic clk = 1'b0;
  logic reset, en, del, clr;
  logic [1:0] tilt_input;
  logic [2:0] switch_input;

  logic [23:0] letters0, letters1;
  logic [1:0]  count0, count1;
  logic        full0, full1, empty0, empty1, err0, err1;

  always #5 clk = ~clk;

  tilt_letter_buffer #(.DEPTH(3), .TILT_W(2), .SW_W(3), .OVERFLOW_SHIFT(0), .BLANK(8'h20)) u_drop (
    .clk(clk), .reset(reset), .en(en), .del(del), .clr(clr),
    .tilt_input(tilt_input), .switch_input(switch_input),
    .letters(letters0), .count(count0), .full(full0), .empty(empty0), .err(err0)
  );

  tilt_letter_buffer #(.DEPTH(3), .TILT_W(2), .SW_W(3), .OVERFLOW_SHIFT(1), .BLANK(8'h20)) u_shift (
    .clk(clk), .reset(reset), .en(en), .del(del), .clr(clr),
    .tilt_input(tilt_input), .switch_input(switch_input),
    .letters(letters1), .count(count1), .full(full1), .empty(empty1), .err(err1)
  );

  typedef struct {
    logic        rst_n, en, del, clr;
    logic [4:0]  code;
    logic [23:0] l0; logic [1:0] c0; logic e0;
    logic [23:0] l1; logic [1:0] c1; logic e1;
  } vec_t;

  vec_t vecs[$];
  int n_vec = 0;
  int n_bad = 0;

  // behavioural reference: one letter list per overflow mode
  logic [7:0] mq0[$], mq1[$];
  logic me0, me1, prev_en, prev_del;

  function automatic logic [23:0] w(input logic [7:0] s0, s1, s2);
    return {s2, s1, s0};
  endfunction

  function automatic logic [23:0] to_vec(input logic [7:0] q[$]);
    logic [23:0] v;
    for (int i = 0; i < 3; i++) v[8*i +: 8] = (i < q.size()) ? q[i] : B;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_buf(input logic [7:0] qi[$], input bit shift, input bit er, input bit dr,
                           input logic c, input logic [4:0] code,
                           output logic [7:0] qo[$], output logic e);
    qo = qi;
    e = 1'b0;
    if (c) qo.delete();
    else if (dr) begin
      if (qo.size() > 0) void'(qo.pop_back());
      else e = 1'b1;
    end else if (er) begin
      if (code >= 26) e = 1'b1;
      else if (qo.size() < 3) qo.push_back(8'h41 + 8'(code));
      else if (shift) begin void'(qo.pop_front()); qo.push_back(8'h41 + 8'(code)); end
      else e = 1'b1;
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic d, input logic c, input logic [4:0] code);
    logic [7:0] t[$];
    bit er, dr;
    if (!r) begin
      mq0.delete(); mq1.delete(); me0 = 0; me1 = 0; prev_en = 1; prev_del = 1;
    end else begin
      er = e & ~prev_en; dr = d & ~prev_del;
      prev_en = e; prev_del = d;
      model_buf(mq0, 1'b0, er, dr, c, code, t, me0); mq0 = t;
      model_buf(mq1, 1'b1, er, dr, c, code, t, me1); mq1 = t;
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic d, input logic c, input logic [4:0] code);
    @(negedge clk);
    reset = r; en = e; del = d; clr = c;
    {tilt_input, switch_input} = code;
    model_step(r, e, d, c, code);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    chk("m0_letters", 32'(letters0), 32'(to_vec(mq0)));
    chk("m0_count",   32'(count0),   32'(mq0.size()));
    chk("m0_full",    32'(full0),    32'(mq0.size() == 3));
    chk("m0_empty",   32'(empty0),   32'(mq0.size() == 0));
    chk("m0_err",     32'(err0),     32'(me0));
    chk("m1_letters", 32'(letters1), 32'(to_vec(mq1)));
    chk("m1_count",   32'(count1),   32'(mq1.size()));
    chk("m1_full",    32'(full1),    32'(mq1.size() == 3));
    chk("m1_empty",   32'(empty1),   32'(mq1.size() == 0));
    chk("m1_err",     32'(err1),     32'(me1));
  endtask

  task automatic add(input logic r, e, d, c, input logic [4:0] code,
                     input logic [23:0] l0, input logic [1:0] c0, input logic e0,
                     input logic [23:0] l1, input logic [1:0] c1, input logic e1);
    vec_t v;
    v.rst_n = r; v.en = e; v.del = d; v.clr = c; v.code = code;
    v.l0 = l0; v.c0 = c0; v.e0 = e0; v.l1 = l1; v.c1 = c1; v.e1 = e1;
    vecs.push_back(v);
  endtask

  initial begin
    logic [23:0] E, A, AN, ANZ, NZG, AN_, NZ_, ANG, A__, N__;
    E = w(B, B, B);        A = w(8'h41, B, B);     AN = w(8'h41, 8'h4E, B);
    ANZ = w(8'h41, 8'h4E, 8'h5A); NZG = w(8'h4E, 8'h5A, 8'h47);
    AN_ = AN; NZ_ = w(8'h4E, 8'h5A, B); ANG = w(8'h41, 8'h4E, 8'h47);
    A__ = A; N__ = w(8'h4E, B, B);

    reset = 0; en = 0; del = 0; clr = 0; tilt_input = 0; switch_input = 0;

    // rst_n en del clr code | drop: letters count err | shift: letters count err
    add(0,1,0,0, 5'd0,  E,2'd0,0,  E,2'd0,0);
    add(0,1,0,0, 5'd0,  E,2'd0,0,  E,2'd0,0);
    add(1,1,0,0, 5'd0,  E,2'd0,0,  E,2'd0,0);   // en held through release: no append
    add(1,0,0,0, 5'd0,  E,2'd0,0,  E,2'd0,0);
    add(1,1,0,0, 5'd0,  A,2'd1,0,  A,2'd1,0);
    add(1,0,0,0, 5'd13, A,2'd1,0,  A,2'd1,0);
    add(1,1,0,0, 5'd13, AN,2'd2,0, AN,2'd2,0);
    add(1,0,0,0, 5'd25, AN,2'd2,0, AN,2'd2,0);
    add(1,1,0,0, 5'd25, ANZ,2'd3,0, ANZ,2'd3,0);
    for (int i = 0; i < 4; i++) add(1,1,0,0, 5'd0, ANZ,2'd3,0, ANZ,2'd3,0);
    add(1,0,0,0, 5'd6,  ANZ,2'd3,0, ANZ,2'd3,0);
    add(1,1,0,0, 5'd6,  ANZ,2'd3,1, NZG,2'd3,0); // full: drop vs shift
    add(1,0,0,0, 5'd6,  ANZ,2'd3,0, NZG,2'd3,0);
    add(1,0,1,0, 5'd6,  AN_,2'd2,0, NZ_,2'd2,0);
    add(1,0,0,0, 5'd6,  AN_,2'd2,0, NZ_,2'd2,0);
    add(1,1,0,0, 5'd6,  ANG,2'd3,0, NZG,2'd3,0);
    add(1,0,0,0, 5'd6,  ANG,2'd3,0, NZG,2'd3,0);
    add(1,0,1,0, 5'd0,  AN_,2'd2,0, NZ_,2'd2,0);
    add(1,0,0,0, 5'd0,  AN_,2'd2,0, NZ_,2'd2,0);
    add(1,0,1,0, 5'd0,  A__,2'd1,0, N__,2'd1,0);
    add(1,0,0,0, 5'd0,  A__,2'd1,0, N__,2'd1,0);
    add(1,0,1,0, 5'd0,  E,2'd0,0,  E,2'd0,0);
    add(1,0,0,0, 5'd0,  E,2'd0,0,  E,2'd0,0);
    add(1,0,1,0, 5'd0,  E,2'd0,1,  E,2'd0,1);   // delete on empty
    add(1,0,0,0, 5'd0,  E,2'd0,0,  E,2'd0,0);
    add(1,1,0,0, 5'd0,  A,2'd1,0,  A,2'd1,0);
    add(1,0,0,0, 5'd13, A,2'd1,0,  A,2'd1,0);
    add(1,1,0,0, 5'd13, AN,2'd2,0, AN,2'd2,0);
    add(1,0,0,0, 5'd26, AN,2'd2,0, AN,2'd2,0);
    add(1,1,0,0, 5'd26, AN,2'd2,1, AN,2'd2,1);  // code 26 invalid
    add(1,0,0,0, 5'd31, AN,2'd2,0, AN,2'd2,0);
    add(1,1,0,0, 5'd31, AN,2'd2,1, AN,2'd2,1);  // code 31 invalid
    add(1,0,0,0, 5'd0,  AN,2'd2,0, AN,2'd2,0);
    add(1,1,1,0, 5'd0,  A,2'd1,0,  A,2'd1,0);   // del wins, no err
    add(1,0,0,0, 5'd13, A,2'd1,0,  A,2'd1,0);
    add(1,1,0,0, 5'd13, AN,2'd2,0, AN,2'd2,0);
    add(1,0,0,0, 5'd25, AN,2'd2,0, AN,2'd2,0);
    add(1,1,0,1, 5'd25, E,2'd0,0,  E,2'd0,0);   // clr consumes en edge
    add(1,1,0,0, 5'd25, E,2'd0,0,  E,2'd0,0);
    add(1,0,0,0, 5'd0,  E,2'd0,0,  E,2'd0,0);
    add(1,1,0,0, 5'd0,  A,2'd1,0,  A,2'd1,0);
    add(1,0,0,0, 5'd13, A,2'd1,0,  A,2'd1,0);
    add(1,1,0,0, 5'd13, AN,2'd2,0, AN,2'd2,0);
    add(1,0,0,0, 5'd0,  AN,2'd2,0, AN,2'd2,0);
    add(0,0,0,0, 5'd0,  E,2'd0,0,  E,2'd0,0);   // reset mid-buffer
    add(1,0,0,0, 5'd0,  E,2'd0,0,  E,2'd0,0);

    foreach (vecs[k]) begin
      drive(vecs[k].rst_n, vecs[k].en, vecs[k].del, vecs[k].clr, vecs[k].code);
      chk("drop_letters", 32'(letters0), 32'(vecs[k].l0));
      chk("drop_count",   32'(count0),   32'(vecs[k].c0));
      chk("drop_full",    32'(full0),    32'(vecs[k].c0 == 2'd3));
      chk("drop_empty",   32'(empty0),   32'(vecs[k].c0 == 2'd0));
      chk("drop_err",     32'(err0),     32'(vecs[k].e0));
      chk("shift_letters", 32'(letters1), 32'(vecs[k].l1));
      chk("shift_count",   32'(count1),   32'(vecs[k].c1));
      chk("shift_err",     32'(err1),     32'(vecs[k].e1));
      check_model();
    end

    // randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      logic r, e, d, c;
      logic [4:0] code;
      r = ($urandom_range(0, 99) != 0);
      e = $urandom_range(0, 1);
      d = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 24) == 0);
      code = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(26, 31)) : 5'($urandom_range(0, 25));
      drive(r, e, d, c, code);
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
